// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TMS-driven FSM clocked by TCK with
// falling-edge registered scan controls and glitch-free gated IR/DR clocks.
module jtag_tap_controller #(
    parameter int IR_SIZE = 4
) (
    input  logic       TCK,
    input  logic       TRST_bar,
    input  logic       TMS,
    input  logic       ir_scan_out,
    input  logic       dr_scan_out,
    output logic [3:0] state,
    output logic       reset_bar,
    output logic       ClockIR,
    output logic       ShiftIR,
    output logic       UpdateIR,
    output logic       ClockDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic       Select,
    output logic       TDO,
    output logic       TDO_enable
);

    // IR width only sizes the external scan cells; reject a degenerate value.
    if (IR_SIZE < 2) begin : g_bad_ir_size
        $error("jtag_tap_controller: IR_SIZE must be at least 2");
    end

    typedef enum logic [3:0] {
        S_EXIT2_DR   = 4'h0,
        S_EXIT1_DR   = 4'h1,
        S_SHIFT_DR   = 4'h2,
        S_PAUSE_DR   = 4'h3,
        S_SEL_IR     = 4'h4,
        S_UPDATE_DR  = 4'h5,
        S_CAPTURE_DR = 4'h6,
        S_SEL_DR     = 4'h7,
        S_EXIT2_IR   = 4'h8,
        S_EXIT1_IR   = 4'h9,
        S_SHIFT_IR   = 4'hA,
        S_PAUSE_IR   = 4'hB,
        S_RTI        = 4'hC,
        S_UPDATE_IR  = 4'hD,
        S_CAPTURE_IR = 4'hE,
        S_TLR        = 4'hF
    } state_t;

    state_t r_state;

    logic r_reset_bar;
    logic r_shift_ir;
    logic r_shift_dr;
    logic r_select;
    logic r_tdo;
    logic r_tdo_en;
    logic r_clkir_en;
    logic r_clkdr_en;
    logic r_updir_en;
    logic r_upddr_en;

    always_ff @(posedge TCK or negedge TRST_bar) begin
        if (!TRST_bar) begin
            r_state <= S_TLR;
        end else begin
            case (r_state)
                S_TLR:        r_state <= TMS ? S_TLR       : S_RTI;
                S_RTI:        r_state <= TMS ? S_SEL_DR    : S_RTI;
                S_SEL_DR:     r_state <= TMS ? S_SEL_IR    : S_CAPTURE_DR;
                S_SEL_IR:     r_state <= TMS ? S_TLR       : S_CAPTURE_IR;
                S_CAPTURE_DR: r_state <= TMS ? S_EXIT1_DR  : S_SHIFT_DR;
                S_SHIFT_DR:   r_state <= TMS ? S_EXIT1_DR  : S_SHIFT_DR;
                S_EXIT1_DR:   r_state <= TMS ? S_UPDATE_DR : S_PAUSE_DR;
                S_PAUSE_DR:   r_state <= TMS ? S_EXIT2_DR  : S_PAUSE_DR;
                S_EXIT2_DR:   r_state <= TMS ? S_UPDATE_DR : S_SHIFT_DR;
                S_UPDATE_DR:  r_state <= TMS ? S_SEL_DR    : S_RTI;
                S_CAPTURE_IR: r_state <= TMS ? S_EXIT1_IR  : S_SHIFT_IR;
                S_SHIFT_IR:   r_state <= TMS ? S_EXIT1_IR  : S_SHIFT_IR;
                S_EXIT1_IR:   r_state <= TMS ? S_UPDATE_IR : S_PAUSE_IR;
                S_PAUSE_IR:   r_state <= TMS ? S_EXIT2_IR  : S_PAUSE_IR;
                S_EXIT2_IR:   r_state <= TMS ? S_UPDATE_IR : S_SHIFT_IR;
                S_UPDATE_IR:  r_state <= TMS ? S_SEL_DR    : S_RTI;
                default:      r_state <= S_TLR;
            endcase
        end
    end

    // Controls change on the falling edge so they are stable around the
    // rising edge where the scan cells sample them.
    always_ff @(negedge TCK or negedge TRST_bar) begin
        if (!TRST_bar) begin
            r_reset_bar <= 1'b0;
            r_shift_ir  <= 1'b0;
            r_shift_dr  <= 1'b0;
            r_select    <= 1'b0;
            r_tdo       <= 1'b0;
            r_tdo_en    <= 1'b0;
            r_clkir_en  <= 1'b0;
            r_clkdr_en  <= 1'b0;
            r_updir_en  <= 1'b0;
            r_upddr_en  <= 1'b0;
        end else begin
            r_reset_bar <= (r_state != S_TLR);
            r_shift_ir  <= (r_state == S_SHIFT_IR);
            r_shift_dr  <= (r_state == S_SHIFT_DR);
            r_select    <= r_state inside {S_CAPTURE_IR, S_SHIFT_IR, S_EXIT1_IR,
                                           S_PAUSE_IR, S_EXIT2_IR, S_UPDATE_IR};
            r_tdo_en    <= (r_state == S_SHIFT_IR) || (r_state == S_SHIFT_DR);
            if (r_state == S_SHIFT_IR) begin
                r_tdo <= ir_scan_out;
            end else if (r_state == S_SHIFT_DR) begin
                r_tdo <= dr_scan_out;
            end
            r_clkir_en  <= (r_state == S_CAPTURE_IR) || (r_state == S_SHIFT_IR);
            r_clkdr_en  <= (r_state == S_CAPTURE_DR) || (r_state == S_SHIFT_DR);
            r_updir_en  <= (r_state == S_UPDATE_IR);
            r_upddr_en  <= (r_state == S_UPDATE_DR);
        end
    end

    assign state      = r_state;
    assign reset_bar  = r_reset_bar;
    assign ShiftIR    = r_shift_ir;
    assign ShiftDR    = r_shift_dr;
    assign Select     = r_select;
    assign TDO        = r_tdo;
    assign TDO_enable = r_tdo_en;

    // Enables only move while TCK is low, so each gate sees a stable enable
    // whenever its TCK term can pass.
    assign ClockIR  = ~(~TCK & r_clkir_en);
    assign ClockDR  = ~(~TCK & r_clkdr_en);
    assign UpdateIR = ~TCK & r_updir_en;
    assign UpdateDR = ~TCK & r_upddr_en;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller: transition/output vector table plus
// hand-written reset, IR scan, paused DR scan and mid-scan TRST sequences.
module tb_jtag_tap_controller;

    logic       TCK = 1'b0;
    logic       TRST_bar = 1'b1;
    logic       TMS = 1'b1;
    logic       ir_scan_out = 1'b0;
    logic       dr_scan_out = 1'b0;
    logic [3:0] state;
    logic       reset_bar, ClockIR, ShiftIR, UpdateIR, ClockDR, ShiftDR, UpdateDR;
    logic       Select, TDO, TDO_enable;

    jtag_tap_controller #(.IR_SIZE(4)) dut (
        .TCK(TCK), .TRST_bar(TRST_bar), .TMS(TMS),
        .ir_scan_out(ir_scan_out), .dr_scan_out(dr_scan_out),
        .state(state), .reset_bar(reset_bar),
        .ClockIR(ClockIR), .ShiftIR(ShiftIR), .UpdateIR(UpdateIR),
        .ClockDR(ClockDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
        .Select(Select), .TDO(TDO), .TDO_enable(TDO_enable)
    );

    always #10 TCK = ~TCK;

    // {reset_bar, Select, ShiftIR, ShiftDR, TDO_enable}
    localparam logic [4:0] O_TLR = 5'b00000, O_IDLE = 5'b10000, O_SDR = 5'b10011,
                           O_IRC = 5'b11000, O_SIR = 5'b11101;
    // {ClockIR, ClockDR, UpdateIR, UpdateDR} during TCK low
    localparam logic [3:0] G_NONE = 4'b1100, G_CIR = 4'b0100, G_CDR = 4'b1000,
                           G_UIR = 4'b1110, G_UDR = 4'b1101;

    typedef struct {
        logic       tms;
        logic [3:0] st;
        logic [4:0] o;
        logic [3:0] g;
    } vec_t;

    vec_t vecs[48];

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_clkir, n_clkdr, n_updir, n_upddr, n_tdoen;
    logic [4:0] shir_bits;
    logic       exp_tdo = 1'b0;
    logic       last_rb_pos;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_counts();
        n_clkir = 0; n_clkdr = 0; n_updir = 0; n_upddr = 0; n_tdoen = 0;
        shir_bits = '0;
    endtask

    // Entered and left at 1 time unit after a falling edge of TCK.
    task automatic tick(input logic tms, input logic [3:0] exp_st);
        logic v_ir, v_dr;
        v_ir = 1'($urandom_range(0, 1));
        v_dr = 1'($urandom_range(0, 1));
        TMS = tms;
        ir_scan_out = v_ir;
        dr_scan_out = v_dr;
        @(posedge TCK); #1;
        chk("state", 8'(state), 8'(exp_st));
        chk("gclk_high", 8'({ClockIR, ClockDR, UpdateIR, UpdateDR}), 8'(G_NONE));
        last_rb_pos = reset_bar;
        @(negedge TCK); #1;
        if (TRST_bar && exp_st == 4'hA) exp_tdo = v_ir;
        else if (TRST_bar && exp_st == 4'h2) exp_tdo = v_dr;
        chk("tdo", 8'(TDO), 8'(exp_tdo));
        if (!ClockIR) begin
            n_clkir++;
            shir_bits = {shir_bits[3:0], ShiftIR};
        end
        if (!ClockDR) n_clkdr++;
        if (UpdateIR) n_updir++;
        if (UpdateDR) n_upddr++;
        if (TDO_enable) n_tdoen++;
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_state"}, 8'(state), 8'hF);
        chk({name, "_outs"}, 8'({reset_bar, Select, ShiftIR, ShiftDR, TDO_enable, TDO}), 8'h00);
        chk({name, "_gclk"}, 8'({ClockIR, ClockDR, UpdateIR, UpdateDR}), 8'(G_NONE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'hF, O_TLR,  G_NONE};
        vecs[1]  = '{1'b0, 4'hC, O_IDLE, G_NONE};
        vecs[2]  = '{1'b0, 4'hC, O_IDLE, G_NONE};
        vecs[3]  = '{1'b1, 4'h7, O_IDLE, G_NONE};
        vecs[4]  = '{1'b1, 4'h4, O_IDLE, G_NONE};
        vecs[5]  = '{1'b1, 4'hF, O_TLR,  G_NONE};
        vecs[6]  = '{1'b0, 4'hC, O_IDLE, G_NONE};
        vecs[7]  = '{1'b1, 4'h7, O_IDLE, G_NONE};
        vecs[8]  = '{1'b0, 4'h6, O_IDLE, G_CDR};
        vecs[9]  = '{1'b0, 4'h2, O_SDR,  G_CDR};
        vecs[10] = '{1'b0, 4'h2, O_SDR,  G_CDR};
        vecs[11] = '{1'b1, 4'h1, O_IDLE, G_NONE};
        vecs[12] = '{1'b0, 4'h3, O_IDLE, G_NONE};
        vecs[13] = '{1'b0, 4'h3, O_IDLE, G_NONE};
        vecs[14] = '{1'b1, 4'h0, O_IDLE, G_NONE};
        vecs[15] = '{1'b0, 4'h2, O_SDR,  G_CDR};
        vecs[16] = '{1'b1, 4'h1, O_IDLE, G_NONE};
        vecs[17] = '{1'b1, 4'h5, O_IDLE, G_UDR};
        vecs[18] = '{1'b0, 4'hC, O_IDLE, G_NONE};
        vecs[19] = '{1'b1, 4'h7, O_IDLE, G_NONE};
        vecs[20] = '{1'b0, 4'h6, O_IDLE, G_CDR};
        vecs[21] = '{1'b1, 4'h1, O_IDLE, G_NONE};
        vecs[22] = '{1'b0, 4'h3, O_IDLE, G_NONE};
        vecs[23] = '{1'b1, 4'h0, O_IDLE, G_NONE};
        vecs[24] = '{1'b1, 4'h5, O_IDLE, G_UDR};
        vecs[25] = '{1'b1, 4'h7, O_IDLE, G_NONE};
        vecs[26] = '{1'b1, 4'h4, O_IDLE, G_NONE};
        vecs[27] = '{1'b0, 4'hE, O_IRC,  G_CIR};
        vecs[28] = '{1'b0, 4'hA, O_SIR,  G_CIR};
        vecs[29] = '{1'b0, 4'hA, O_SIR,  G_CIR};
        vecs[30] = '{1'b1, 4'h9, O_IRC,  G_NONE};
        vecs[31] = '{1'b0, 4'hB, O_IRC,  G_NONE};
        vecs[32] = '{1'b0, 4'hB, O_IRC,  G_NONE};
        vecs[33] = '{1'b1, 4'h8, O_IRC,  G_NONE};
        vecs[34] = '{1'b0, 4'hA, O_SIR,  G_CIR};
        vecs[35] = '{1'b1, 4'h9, O_IRC,  G_NONE};
        vecs[36] = '{1'b1, 4'hD, O_IRC,  G_UIR};
        vecs[37] = '{1'b0, 4'hC, O_IDLE, G_NONE};
        vecs[38] = '{1'b1, 4'h7, O_IDLE, G_NONE};
        vecs[39] = '{1'b1, 4'h4, O_IDLE, G_NONE};
        vecs[40] = '{1'b0, 4'hE, O_IRC,  G_CIR};
        vecs[41] = '{1'b1, 4'h9, O_IRC,  G_NONE};
        vecs[42] = '{1'b0, 4'hB, O_IRC,  G_NONE};
        vecs[43] = '{1'b1, 4'h8, O_IRC,  G_NONE};
        vecs[44] = '{1'b1, 4'hD, O_IRC,  G_UIR};
        vecs[45] = '{1'b1, 4'h7, O_IDLE, G_NONE};
        vecs[46] = '{1'b1, 4'h4, O_IDLE, G_NONE};
        vecs[47] = '{1'b1, 4'hF, O_TLR,  G_NONE};

        clr_counts();

        // Asynchronous reset and release
        #3 TRST_bar = 1'b0;
        #2 chk_reset_outs("rst_async");
        repeat (2) @(negedge TCK);
        #1 chk_reset_outs("rst_hold");
        TRST_bar = 1'b1;
        tick(1'b0, 4'hC);
        chk("rb_before_fall", 8'(last_rb_pos), 8'h0);
        chk("rb_after_fall", 8'(reset_bar), 8'h1);
        chk("post_rst_outs", 8'({Select, ShiftIR, ShiftDR, TDO_enable, TDO}), 8'h00);

        // From Shift-DR, five TMS=1 edges reach TLR
        tick(1'b1, 4'h7);
        tick(1'b0, 4'h6);
        tick(1'b0, 4'h2);
        chk("sdr_outs", 8'({reset_bar, Select, ShiftIR, ShiftDR, TDO_enable}), 8'(O_SDR));
        tick(1'b1, 4'h1);
        tick(1'b1, 4'h5);
        tick(1'b1, 4'h7);
        tick(1'b1, 4'h4);
        tick(1'b1, 4'hF);
        chk("five_ones_rb", 8'(reset_bar), 8'h0);

        // All 32 (state, TMS) pairs starting from TLR
        for (int i = 0; i < 48; i++) begin
            tick(vecs[i].tms, vecs[i].st);
            chk("vec_out", 8'({reset_bar, Select, ShiftIR, ShiftDR, TDO_enable}), 8'(vecs[i].o));
            chk("vec_gclk", 8'({ClockIR, ClockDR, UpdateIR, UpdateDR}), 8'(vecs[i].g));
        end

        // IR scan with four Shift-IR edges
        tick(1'b0, 4'hC);
        clr_counts();
        tick(1'b1, 4'h7);
        tick(1'b1, 4'h4);
        tick(1'b0, 4'hE);
        tick(1'b0, 4'hA);
        tick(1'b0, 4'hA);
        tick(1'b0, 4'hA);
        tick(1'b0, 4'hA);
        tick(1'b1, 4'h9);
        tick(1'b1, 4'hD);
        tick(1'b0, 4'hC);
        chk("ir_clk_edges", 8'(n_clkir), 8'd5);
        chk("ir_shift_at_clk", 8'(shir_bits), 8'b01111);
        chk("ir_upd_pulses", 8'(n_updir), 8'd1);
        chk("ir_tdo_en_cnt", 8'(n_tdoen), 8'd4);
        chk("ir_no_dr_clk", 8'(n_clkdr + n_upddr), 8'd0);

        // DR scan with a three-edge pause in the middle
        clr_counts();
        tick(1'b1, 4'h7);
        tick(1'b0, 4'h6);
        tick(1'b0, 4'h2);
        tick(1'b0, 4'h2);
        tick(1'b1, 4'h1);
        chk("dr_clk_pre_pause", 8'(n_clkdr), 8'd3);
        tick(1'b0, 4'h3);
        tick(1'b0, 4'h3);
        tick(1'b0, 4'h3);
        tick(1'b1, 4'h0);
        chk("dr_clk_in_pause", 8'(n_clkdr), 8'd3);
        tick(1'b0, 4'h2);
        tick(1'b0, 4'h2);
        tick(1'b1, 4'h1);
        tick(1'b1, 4'h5);
        tick(1'b0, 4'hC);
        chk("dr_clk_edges", 8'(n_clkdr), 8'd5);
        chk("dr_upd_pulses", 8'(n_upddr), 8'd1);
        chk("dr_tdo_en_cnt", 8'(n_tdoen), 8'd4);
        chk("dr_no_ir_clk", 8'(n_clkir + n_updir), 8'd0);

        // TRST asserted mid Shift-IR while ClockIR is low
        tick(1'b1, 4'h7);
        tick(1'b1, 4'h4);
        tick(1'b0, 4'hE);
        tick(1'b0, 4'hA);
        chk("mid_clkir_low", 8'(ClockIR), 8'h0);
        TRST_bar = 1'b0;
        exp_tdo = 1'b0;
        #1 chk_reset_outs("mid_rst");
        clr_counts();
        tick(1'b0, 4'hF);
        tick(1'b1, 4'hF);
        tick(1'b1, 4'hF);
        chk("mid_rst_no_upd", 8'(n_updir + n_clkir), 8'd0);
        chk_reset_outs("mid_rst_hold");
        TRST_bar = 1'b1;
        tick(1'b0, 4'hC);
        chk("mid_rst_recover_rb", 8'(reset_bar), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
